// File: rtl/awgn_pkg.sv
// Q-format widths, rounding constants, saturation limits and output FSM encoding
// shared by the AWGN sample combiner and its multiply/round path.
package awgn_pkg;

  localparam int F_W       = 17;  // radius, unsigned Q4.13
  localparam int G_W       = 16;  // trig term, signed Q1.15
  localparam int OUT_W     = 16;  // noise sample, signed Q5.11
  localparam int P_W       = F_W + G_W;  // product, signed Q5.28
  localparam int RND_SHIFT = 17;

  localparam logic signed [P_W-1:0]   RND_BIAS = P_W'(1) << (RND_SHIFT - 1);
  localparam logic signed [OUT_W-1:0] SAT_MAX  = 16'sh7FFF;
  localparam logic signed [OUT_W-1:0] SAT_MIN  = 16'sh8000;

  typedef enum logic {
    EMIT_X0 = 1'b0,
    EMIT_X1 = 1'b1
  } emit_state_t;

  // Saturation bounds for an arbitrary output width, in product precision.
  function automatic logic signed [P_W-1:0] sat_hi(input int w);
    return (P_W'(1) << (w - 1)) - P_W'(1);
  endfunction

  function automatic logic signed [P_W-1:0] sat_lo(input int w);
    return ~sat_hi(w);
  endfunction

endpackage

// File: rtl/awgn_mul_round.sv
// Two-stage f*g multiply then round-half-up/saturate to OUT_W; latency 2 cycles.
// Free-running, no stall: valid tracking lives in the parent.
module awgn_mul_round
  import awgn_pkg::*;
#(
  parameter int OUT_W = awgn_pkg::OUT_W
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [F_W-1:0]          f,
  input  logic signed [G_W-1:0]   g,
  output logic signed [OUT_W-1:0] x
);

  localparam logic signed [P_W-1:0] HI = sat_hi(OUT_W);
  localparam logic signed [P_W-1:0] LO = sat_lo(OUT_W);

  logic signed [P_W-1:0]   f_ext;
  logic signed [P_W-1:0]   g_ext;
  logic signed [P_W-1:0]   prod_d;
  logic signed [P_W-1:0]   prod_q;
  logic signed [P_W-1:0]   biased;
  logic signed [P_W-1:0]   shifted;
  logic signed [OUT_W-1:0] x_d;

  // f is a magnitude, so it is zero-extended; g keeps its sign.
  always_comb begin
    f_ext  = {{(P_W - F_W){1'b0}}, f};
    g_ext  = {{(P_W - G_W){g[G_W-1]}}, g};
    prod_d = f_ext * g_ext;
  end

  always_comb begin
    biased  = prod_q + RND_BIAS;
    shifted = biased >>> RND_SHIFT;
    if (shifted > HI) begin
      x_d = HI[OUT_W-1:0];
    end else if (shifted < LO) begin
      x_d = LO[OUT_W-1:0];
    end else begin
      x_d = shifted[OUT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
      x      <= '0;
    end else begin
      prod_q <= prod_d;
      x      <= x_d;
    end
  end

endmodule

// File: rtl/awgn_sample_combiner.sv
// Turns (f, g0, g1) triples into serialised x0/x1 noise samples; first x0 valid 3 cycles after acceptance.
// Non-stalling pipeline with credit-based in_ready: accepts only while FIFO occupancy + in-flight < DEPTH.
module awgn_sample_combiner
  import awgn_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OUT_W = awgn_pkg::OUT_W
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [F_W-1:0]          f_in,
  input  logic signed [G_W-1:0]   g0_in,
  input  logic signed [G_W-1:0]   g1_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    alive;
  logic                    v1;
  logic                    v2;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W:0]          committed;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic signed [OUT_W-1:0] x0_q;
  logic signed [OUT_W-1:0] x1_q;
  logic signed [OUT_W-1:0] mem_x0 [DEPTH];
  logic signed [OUT_W-1:0] mem_x1 [DEPTH];
  emit_state_t             state;
  emit_state_t             state_nxt;

  awgn_mul_round #(.OUT_W(OUT_W)) u_mul_x0 (
    .clock   (clock),
    .reset_n (reset_n),
    .f       (f_in),
    .g       (g0_in),
    .x       (x0_q)
  );

  awgn_mul_round #(.OUT_W(OUT_W)) u_mul_x1 (
    .clock   (clock),
    .reset_n (reset_n),
    .f       (f_in),
    .g       (g1_in),
    .x       (x1_q)
  );

  // Credits count pairs already in the pipe, so the FIFO can never overflow.
  // alive keeps in_ready low while reset is held and for the release cycle.
  assign committed = {1'b0, count} + (CNT_W + 1)'(v1) + (CNT_W + 1)'(v2);
  assign in_ready  = alive && (committed < (CNT_W + 1)'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = v2;
  assign pop       = out_valid && out_ready && (state == EMIT_X1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alive  <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= EMIT_X0;
    end else begin
      alive <= 1'b1;
      v1    <= accept;
      v2    <= v1;
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_x0[wr_ptr] <= x0_q;
      mem_x1[wr_ptr] <= x1_q;
    end
  end

  always_comb begin
    state_nxt = state;
    out_valid = (count != '0);
    out_sel   = (state == EMIT_X1);
    out_data  = '0;
    if (out_valid) begin
      out_data = out_sel ? mem_x1[rd_ptr] : mem_x0[rd_ptr];
      if (out_ready) begin
        case (state)
          EMIT_X0: state_nxt = EMIT_X1;
          EMIT_X1: state_nxt = EMIT_X0;
          default: state_nxt = EMIT_X0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_awgn_sample_combiner.sv
// Bench for awgn_sample_combiner: directed latency/saturation cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_awgn_sample_combiner;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [16:0] f_in = '0;
  logic [15:0] g0_in = '0;
  logic [15:0] g1_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_sel;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q [$];  // {sel, data}

  always #5 clock = ~clock;

  awgn_sample_combiner #(.DEPTH(4), .OUT_W(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .f_in      (f_in),
    .g0_in     (g0_in),
    .g1_in     (g1_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Real-number meaning: round(f * g * 2^11) half-up, clamped to 16-bit signed.
  function automatic logic [15:0] ref_x(input logic [16:0] f, input logic [15:0] g);
    longint p, s, q;
    p = longint'(f) * longint'($signed(g));
    s = p + 65536;
    q = s / 131072;
    if (s < 0 && (s % 131072) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic model_accept(input logic [16:0] f, input logic [15:0] g0, input logic [15:0] g1);
    exp_q.push_back({1'b0, ref_x(f, g0)});
    exp_q.push_back({1'b1, ref_x(f, g1)});
  endtask

  task automatic rand_triple();
    f_in  = 17'($urandom);
    g0_in = 16'($urandom);
    g1_in = 16'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_sel !== 1'b0) begin errors++; $display("FAIL reset_out_sel got %b want 0", out_sel); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_single(input logic [16:0] f, input logic [15:0] g0, input logic [15:0] g1,
                             input logic [15:0] e0, input logic [15:0] e1, input string tag);
    logic exp_v;
    @(posedge clock); #1;
    out_ready = 1'b1; in_valid = 1'b1; f_in = f; g0_in = g0; g1_in = g1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clock);
      exp_v = (k == 3 || k == 4);
      if (k == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept in_ready got %b want 1", tag, in_ready); end
      end
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL %s_valid_t%0d got %b want %b", tag, k, out_valid, exp_v); end
      if (k == 3) begin
        checks++; if ({out_sel, out_data} !== {1'b0, e0}) begin errors++; $display("FAIL %s_x0 got sel %b data %h want sel 0 data %h", tag, out_sel, out_data, e0); end
      end
      if (k == 4) begin
        checks++; if ({out_sel, out_data} !== {1'b1, e1}) begin errors++; $display("FAIL %s_x1 got sel %b data %h want sel 1 data %h", tag, out_sel, out_data, e1); end
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int n = 0;
    int cyc = 0;
    logic x1_popped = 1'b0;
    logic credit_checked = 1'b0;
    logic [16:0] e;
    @(posedge clock); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; rand_triple();
      @(negedge clock);
      if (in_ready) begin acc++; model_accept(f_in, g0_in, g1_in); end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    @(negedge clock);
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_out_valid got %b want 1", out_valid); end
    @(posedge clock); #1;
    out_ready = 1'b1;
    while (n < 8 && cyc < 40) begin
      @(negedge clock);
      if (x1_popped && !credit_checked) begin
        credit_checked = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_credit_return in_ready got %b want 1", in_ready); end
      end
      if (out_valid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1_dead;
        checks++; if ({out_sel, out_data} !== e) begin errors++; $display("FAIL bp_sample%0d got sel %b data %h want sel %b data %h", n, out_sel, out_data, e[16], e[15:0]); end
        checks++; if (out_sel !== 1'(n % 2)) begin errors++; $display("FAIL bp_sel_order%0d got %b want %0d", n, out_sel, n % 2); end
        if (out_sel) x1_popped = 1'b1;
        n++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL bp_drain_count got %0d want 8", n); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_hold();
    int acc = 0;
    int cyc = 0;
    logic pend = 1'b0;
    logic stall_prev = 1'b0;
    logic [15:0] pd = '0;
    logic ps = 1'b0;
    logic [16:0] e;
    while ((acc < 100 || exp_q.size() != 0) && cyc < 4000) begin
      @(posedge clock); #1;
      if (acc >= 100) begin
        in_valid = 1'b0;
      end else if (!pend) begin
        rand_triple();
        in_valid = ($urandom_range(3) != 0);
        pend = in_valid;
      end
      out_ready = 1'($urandom_range(1));
      @(negedge clock);
      if (in_valid && in_ready) begin model_accept(f_in, g0_in, g1_in); acc++; pend = 1'b0; end
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_sel !== ps) begin
          errors++; $display("FAIL hold_stable cyc %0d got v %b sel %b data %h want v 1 sel %b data %h", cyc, out_valid, out_sel, out_data, ps, pd);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL hold_spurious cyc %0d got sel %b data %h want no sample", cyc, out_sel, out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_sel, out_data} !== e) begin errors++; $display("FAIL hold_sample cyc %0d got sel %b data %h want sel %b data %h", cyc, out_sel, out_data, e[16], e[15:0]); end
        end
      end
      stall_prev = out_valid && !out_ready;
      pd = out_data; ps = out_sel;
      cyc++;
    end
    checks++; if (acc != 100 || exp_q.size() != 0) begin errors++; $display("FAIL hold_complete got acc %0d left %0d want acc 100 left 0", acc, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [16:0] e;
    int seen = 0;
    @(posedge clock); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; rand_triple();
      @(negedge clock);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_fill%0d in_ready got %b want 1", i, in_ready); end
      if (in_ready) model_accept(f_in, g0_in, g1_in);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    out_ready = 1'b1;
    @(negedge clock);
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_sel, out_data} !== e) begin errors++; $display("FAIL mid_x0 got v %b sel %b data %h want v 1 sel %b data %h", out_valid, out_sel, out_data, e[16], e[15:0]); end
    @(posedge clock); #1;
    out_ready = 1'b0;
    @(negedge clock);
    checks++; if (out_sel !== 1'b1 || out_data !== exp_q[0][15:0]) begin errors++; $display("FAIL mid_x1_present got sel %b data %h want sel 1 data %h", out_sel, out_data, exp_q[0][15:0]); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_sel !== 1'b0) begin errors++; $display("FAIL mid_rst_out_sel got %b want 0", out_sel); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL mid_rst_out_data got %h want 0000", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
    #1 reset_n = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      @(negedge clock);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_after%0d got valid %b ready %b want valid 0 ready 1", k, out_valid, in_ready); end
    end
    @(posedge clock); #1;
    in_valid = 1'b1; rand_triple();
    model_accept(f_in, g0_in, g1_in);
    for (int k = 0; k < 10 && seen < 2; k++) begin
      @(negedge clock);
      if (out_valid) begin
        e = exp_q.pop_front();
        checks++; if ({out_sel, out_data} !== e) begin errors++; $display("FAIL mid_restart%0d got sel %b data %h want sel %b data %h", seen, out_sel, out_data, e[16], e[15:0]); end
        seen++;
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
    end
    checks++; if (seen != 2) begin errors++; $display("FAIL mid_restart_count got %0d want 2", seen); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(17'h02000, 16'h4000, 16'hC000, 16'h0400, 16'hFC00, "basic");
    test_single(17'h1FFFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, "sat");
    test_backpressure();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/awgn_sample_combiner.md
AWGN_SAMPLE_COMBINER -- requirements
Module: awgn_sample_combiner

Interface
REQ-001 Parameter DEPTH, default 4: FIFO capacity in sample pairs; power of two, at least 2.
REQ-002 Parameter OUT_W, default 16: output sample width.
REQ-003 Port clock, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port f_in, input, 17: unsigned radius sqrt(-2 ln u0), format Q4.13.
REQ-006 Port g0_in, input, 16: signed cosine term, format Q1.15.
REQ-007 Port g1_in, input, 16: signed sine term, format Q1.15.
REQ-008 Port in_valid, input, 1: f_in, g0_in and g1_in are valid this cycle.
REQ-009 Port in_ready, output, 1: block accepts a triple this cycle.
REQ-010 Port out_data, output, OUT_W: signed noise sample, format Q5.11.
REQ-011 Port out_sel, output, 1: 0 = x0 (f*g0), 1 = x1 (f*g1).
REQ-012 Port out_valid, output, 1: out_data and out_sel are valid.
REQ-013 Port out_ready, input, 1: downstream accepts the current sample.

Function
REQ-014 Input acceptance SHALL occur only when in_valid and in_ready are both 1; each accepted triple produces exactly one pair x0, x1.
REQ-015 Products SHALL be f*g as a signed 33-bit Q5.28 value, with f zero-extended before the multiply.
REQ-016 Output conversion SHALL add 2^16, arithmetic-shift right by 17, then saturate to the range 0x8000..0x7FFF.
REQ-017 The multiply path SHALL be two register stages: multiply, then round/saturate. The pair is written to the FIFO at the end of cycle t+2 for acceptance in cycle t.
REQ-018 The pipeline SHALL NOT stall; backpressure SHALL be credit-based.
REQ-019 in_ready SHALL be 1 if and only if (FIFO occupancy + pairs in flight) < DEPTH.
REQ-020 in_ready SHALL be computed from registered state only, with no combinational path from out_ready.
REQ-021 The FIFO SHALL store {x0, x1} pairs in circular order, with wrap-around read and write pointers and an occupancy counter from 0 to DEPTH.
REQ-022 Output sequencing SHALL use an FSM with two states, EMIT_X0 and EMIT_X1.
REQ-023 In EMIT_X0, the block SHALL present the head x0 with out_sel=0; on handshake it SHALL move to EMIT_X1.
REQ-024 In EMIT_X1, the block SHALL present the head x1 with out_sel=1; on handshake it SHALL pop the pair and return to EMIT_X0.
REQ-025 out_valid SHALL equal (occupancy != 0). out_data and out_sel SHALL hold steady while out_valid=1 and out_ready=0.
REQ-026 Minimum latency SHALL be: acceptance in cycle t into an empty FIFO gives x0 valid in cycle t+3.
REQ-027 Simultaneous FIFO write and pop of the last pair SHALL leave occupancy unchanged, with no loss and no duplicate.
REQ-028 At full occupancy with no credit, in_ready=0; the cycle after the x1 pop, in_ready SHALL return to 1.
REQ-029 The FIFO SHALL never overflow, and out_valid SHALL never assert when the FIFO is empty.

Reset
REQ-030 Asserting reset_n=0 SHALL immediately clear the pointers, occupancy and in-flight valid bits, and set the FSM to EMIT_X0.
REQ-031 During reset, out_valid=0, out_sel=0, out_data=0 and in_ready=0.
REQ-032 In-flight and buffered samples SHALL be discarded on reset mid-operation.
REQ-033 in_ready SHALL rise in the first cycle after reset_n deasserts.

Structure
REQ-034 Package awgn_pkg SHALL hold the Q-format widths (F_W=17, G_W=16, OUT_W=16), the rounding shift 17, the saturation limits, and the FSM state encoding.
REQ-035 The block SHALL have one sub-module, awgn_mul_round, holding the two-stage multiply/round/saturate path; it SHALL be instantiated twice, once for x0 and once for x1.

Verification
REQ-036 Basic: f=0x02000, g0=0x4000, g1=0xC000, out_ready=1 -> out_data 0x0400 (sel 0) at t+3, then 0xFC00 (sel 1) at t+4.
REQ-037 Saturation: f=0x1FFFF, g0=0x7FFF, g1=0x8000 -> 0x7FFF, then 0x8000.
REQ-038 Backpressure: out_ready=0, drive 6 valid triples -> exactly 4 accepted and in_ready low; then out_ready=1 -> 8 samples in order with sel alternating 0,1.
REQ-039 Hold: out_ready toggled pseudo-randomly over 100 triples -> every sample matches the reference model, with no drops and stable data while stalled.
REQ-040 Reset mid-operation: FIFO holding 3 pairs, pulse reset_n low between clock edges -> outputs zero asynchronously; after release, out_valid=0 until new input and in_ready=1.
